// File: rtl/control_sequencer_pkg.sv
// Shared constants for the SAP-1 control sequencer: control-word bit indices,
// opcodes and the one-hot T-state encoding.
package control_sequencer_pkg;

  localparam int CW_W = 12;

  localparam int EN_PC  = 0;
  localparam int INC_PC = 1;
  localparam int LD_MAR = 2;
  localparam int EN_MEM = 3;
  localparam int LD_IR  = 4;
  localparam int EN_IR  = 5;
  localparam int LD_AR  = 6;
  localparam int EN_AR  = 7;
  localparam int SUB    = 8;
  localparam int EN_ALU = 9;
  localparam int LD_BR  = 10;
  localparam int LD_OUT = 11;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // All-zero is the halted encoding; the six ring positions are one-hot.
  typedef enum logic [5:0] {
    T_NONE = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } t_state_e;

  function automatic logic [CW_W-1:0] cw(input int unsigned idx);
    return CW_W'(1) << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_t_state_ring.sv
// One-hot T1..T6 ring counter with early wrap to T1 and a forced-zero
// (halted) position that only reset leaves.
module control_sequencer_t_state_ring
  import control_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       wrap,
  input  logic       hold_zero,
  output logic [5:0] t_state
);

  t_state_e state_q;
  t_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= T1;
    else     state_q <= state_d;
  end

  // hold_zero outranks advancing so HLT wins over any early wrap in T4.
  always_comb begin
    state_d = state_q;
    if (hold_zero) begin
      state_d = T_NONE;
    end else if (adv) begin
      if (wrap) begin
        state_d = T1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign t_state = state_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control unit: drives the ring counter, latches HALT and decodes
// (T-state, opcode) into the 12-bit control word.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter bit SKIP_NOP = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [3:0]      ir_opcode,
  output logic [CW_W-1:0] control_word,
  output logic [5:0]      t_state,
  output logic            halt
);

  logic            halt_q;
  logic            adv;
  logic            wrap;
  logic            hlt_exec;
  logic            known_op;
  logic [CW_W-1:0] decoded;

  assign adv      = run & ~halt_q;
  assign hlt_exec = adv & t_state[3] & (ir_opcode == OP_HLT);
  assign known_op = (ir_opcode == OP_LDA) | (ir_opcode == OP_ADD) |
                    (ir_opcode == OP_SUB);
  assign wrap     = SKIP_NOP & ((t_state[4] & (ir_opcode == OP_LDA)) |
                                (t_state[3] & ~known_op));

  control_sequencer_t_state_ring u_ring (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .wrap      (wrap),
    .hold_zero (halt_q | hlt_exec),
    .t_state   (t_state)
  );

  always_ff @(posedge clk) begin
    if (rst)           halt_q <= 1'b0;
    else if (hlt_exec) halt_q <= 1'b1;
  end

  // Fetch ignores the opcode because IR is still being loaded during T1..T3.
  always_comb begin
    decoded = '0;
    case (t_state)
      T1: decoded = cw(EN_PC) | cw(LD_MAR);
      T2: decoded = cw(INC_PC);
      T3: decoded = cw(EN_MEM) | cw(LD_IR);
      T4: begin
        if (known_op)                 decoded = cw(EN_IR) | cw(LD_MAR);
        else if (ir_opcode == OP_OUT) decoded = cw(EN_AR) | cw(LD_OUT);
      end
      T5: begin
        if (ir_opcode == OP_LDA)      decoded = cw(EN_MEM) | cw(LD_AR);
        else if (ir_opcode == OP_ADD) decoded = cw(EN_MEM) | cw(LD_BR);
        else if (ir_opcode == OP_SUB) decoded = cw(EN_MEM) | cw(LD_BR) | cw(SUB);
      end
      T6: begin
        if (ir_opcode == OP_ADD)      decoded = cw(EN_ALU) | cw(LD_AR);
        else if (ir_opcode == OP_SUB) decoded = cw(EN_ALU) | cw(LD_AR) | cw(SUB);
      end
      default: decoded = '0;
    endcase
  end

  assign control_word = (rst | ~run | halt_q) ? '0 : decoded;
  assign halt         = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a directed vector table, hand
// sequences for pause/halt/reset corners, and random traffic against a model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  ir_opcode = 4'h0;
  logic [11:0] cw0, cw1;
  logic [5:0]  ts0, ts1;
  logic        halt0, halt1;

  int tests = 0;
  int fails = 0;

  // Model state per DUT: index 0 is SKIP_NOP=0, index 1 is SKIP_NOP=1.
  // m_t holds the T-state number 1..6, 0 when halted.
  int m_t[2];
  bit m_halt[2];

  typedef struct {
    bit          rst;
    bit          run;
    logic [3:0]  op;
    logic [11:0] cw;
    logic [5:0]  ts;
    bit          halt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  control_sequencer #(.SKIP_NOP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
    .control_word(cw0), .t_state(ts0), .halt(halt0)
  );

  control_sequencer #(.SKIP_NOP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
    .control_word(cw1), .t_state(ts1), .halt(halt1)
  );

  // Microcode table straight from the instruction listing.
  function automatic logic [11:0] ref_word(input int t, input logic [3:0] op);
    case (t)
      1: return 12'h005;
      2: return 12'h002;
      3: return 12'h018;
      4: if (op <= 4'h2) return 12'h024; else if (op == 4'hE) return 12'h880; else return 12'h000;
      5: if (op == 4'h0) return 12'h048; else if (op == 4'h1) return 12'h408;
         else if (op == 4'h2) return 12'h508; else return 12'h000;
      6: if (op == 4'h1) return 12'h240; else if (op == 4'h2) return 12'h340; else return 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit r, input bit u, input logic [3:0] op,
                         input logic [11:0] w, input logic [5:0] t, input bit h);
    vec_t v;
    v.rst = r; v.run = u; v.op = op; v.cw = w; v.ts = t; v.halt = h;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input bit r, input bit u, input logic [3:0] op);
    rst = r;
    run = u;
    ir_opcode = op;
    #1;
  endtask

  // Compares both DUTs against the model, including the bus-driver onehot0 rule.
  task automatic check_output();
    for (int d = 0; d < 2; d++) begin
      logic [11:0] w, exp_w;
      logic [5:0]  t, exp_t;
      logic        h;
      w = (d == 0) ? cw0 : cw1;
      t = (d == 0) ? ts0 : ts1;
      h = (d == 0) ? halt0 : halt1;
      exp_w = (rst || !run || m_halt[d]) ? 12'h000 : ref_word(m_t[d], ir_opcode);
      exp_t = (m_t[d] == 0) ? 6'b0 : 6'(1 << (m_t[d] - 1));
      check_val($sformatf("model%0d_cw", d), 32'(w), 32'(exp_w));
      check_val($sformatf("model%0d_tstate", d), 32'(t), 32'(exp_t));
      check_val($sformatf("model%0d_halt", d), 32'(h), 32'(m_halt[d]));
      check_val($sformatf("model%0d_onehot0", d),
                32'($countones({w[0], w[3], w[5], w[7], w[9]}) <= 1), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_t[d] = 1;
        m_halt[d] = 1'b0;
      end else if (!m_halt[d] && run) begin
        if (m_t[d] == 4 && ir_opcode == 4'hF) begin
          m_halt[d] = 1'b1;
          m_t[d] = 0;
        end else if (d == 1 && ((m_t[d] == 5 && ir_opcode == 4'h0) ||
                                (m_t[d] == 4 && ir_opcode > 4'h2))) begin
          m_t[d] = 1;
        end else begin
          m_t[d] = (m_t[d] % 6) + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit u, input logic [3:0] op);
    apply_stimulus(r, u, op);
    check_output();
    tick();
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 4'h0);
    tick();
  endtask

  initial begin
    // Directed vectors for the SKIP_NOP=0 instance; state shown is before the edge.
    add_vec(0,1,4'h0,12'h005,6'h01,0); add_vec(0,1,4'h0,12'h002,6'h02,0);
    add_vec(0,1,4'h0,12'h018,6'h04,0); add_vec(0,1,4'h0,12'h024,6'h08,0);
    add_vec(0,1,4'h0,12'h048,6'h10,0); add_vec(0,1,4'h0,12'h000,6'h20,0);
    add_vec(0,1,4'h0,12'h005,6'h01,0); add_vec(0,1,4'h1,12'h002,6'h02,0);
    add_vec(0,1,4'h1,12'h018,6'h04,0); add_vec(0,1,4'h1,12'h024,6'h08,0);
    add_vec(0,1,4'h1,12'h408,6'h10,0); add_vec(0,1,4'h1,12'h240,6'h20,0);
    add_vec(0,1,4'h2,12'h005,6'h01,0); add_vec(0,1,4'h2,12'h002,6'h02,0);
    add_vec(0,1,4'h2,12'h018,6'h04,0); add_vec(0,1,4'h2,12'h024,6'h08,0);
    add_vec(0,1,4'h2,12'h508,6'h10,0); add_vec(0,1,4'h2,12'h340,6'h20,0);
    add_vec(0,0,4'h2,12'h000,6'h01,0); add_vec(1,0,4'h2,12'h000,6'h01,0);
    add_vec(0,1,4'hE,12'h005,6'h01,0); add_vec(0,1,4'hE,12'h002,6'h02,0);
    add_vec(0,1,4'hE,12'h018,6'h04,0); add_vec(0,1,4'hE,12'h880,6'h08,0);
    add_vec(0,1,4'hE,12'h000,6'h10,0); add_vec(0,1,4'hE,12'h000,6'h20,0);
    add_vec(0,1,4'hF,12'h005,6'h01,0); add_vec(0,1,4'hF,12'h002,6'h02,0);
    add_vec(0,1,4'hF,12'h018,6'h04,0); add_vec(0,1,4'hF,12'h000,6'h08,0);
    add_vec(0,1,4'hF,12'h000,6'h00,1); add_vec(0,0,4'h1,12'h000,6'h00,1);
    add_vec(1,1,4'h0,12'h000,6'h00,1); add_vec(0,1,4'h0,12'h005,6'h01,0);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].run, vecs[i].op);
      check_val($sformatf("vec%0d_cw", i), 32'(cw0), 32'(vecs[i].cw));
      check_val($sformatf("vec%0d_tstate", i), 32'(ts0), 32'(vecs[i].ts));
      check_val($sformatf("vec%0d_halt", i), 32'(halt0), 32'(vecs[i].halt));
      check_output();
      tick();
    end

    // OUT with early wrap on the SKIP_NOP=1 instance.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 4'hE);
    apply_stimulus(0, 1, 4'hE);
    check_val("out_skip_t4_cw", 32'(cw1), 32'h880);
    check_val("out_skip_t4_ts", 32'(ts1), 32'h08);
    tick();
    apply_stimulus(0, 1, 4'hE);
    check_val("out_skip_wrap_ts", 32'(ts1), 32'h01);
    check_output();
    tick();

    // Pause for three cycles in ADD T3, then resume.
    do_reset();
    step(0, 1, 4'h1);
    step(0, 1, 4'h1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 4'h1);
      check_val($sformatf("pause%0d_cw", i), 32'(cw0), 32'h000);
      check_val($sformatf("pause%0d_ts", i), 32'(ts0), 32'h04);
      check_output();
      tick();
    end
    apply_stimulus(0, 1, 4'h1);
    check_val("resume_cw", 32'(cw0), 32'h018);
    check_val("resume_ts", 32'(ts0), 32'h04);
    tick();
    apply_stimulus(0, 1, 4'h1);
    check_val("resume_next_ts", 32'(ts0), 32'h08);
    check_output();
    tick();

    // HLT, then ten cycles of noise on RUN/IR_OPCODE, then reset.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 4'hF);
    apply_stimulus(0, 1, 4'hF);
    check_val("hlt_t4_cw", 32'(cw0), 32'h000);
    check_val("hlt_t4_halt", 32'(halt0), 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      check_val($sformatf("halted%0d_ts", i), 32'(ts0), 32'h00);
      check_val($sformatf("halted%0d_halt", i), 32'(halt0), 32'h1);
      check_val($sformatf("halted%0d_cw", i), 32'(cw0), 32'h000);
      check_val($sformatf("halted%0d_halt1", i), 32'(halt1), 32'h1);
      tick();
    end
    apply_stimulus(1, 1, 4'h0);
    tick();
    apply_stimulus(0, 1, 4'h0);
    check_val("hlt_reset_ts", 32'(ts0), 32'h01);
    check_val("hlt_reset_halt", 32'(halt0), 32'h0);
    tick();

    // Reset in the middle of LDA T5.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 4'h0);
    apply_stimulus(1, 1, 4'h0);
    check_val("rst_t5_before_ts", 32'(ts0), 32'h10);
    tick();
    apply_stimulus(0, 1, 4'h0);
    check_val("rst_t5_after_ts", 32'(ts0), 32'h01);
    tick();

    // Random opcode/RUN/RST traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int pick;
      logic [3:0] op;
      pick = $urandom_range(0, 9);
      if (pick < 2)       op = 4'h0;
      else if (pick < 4)  op = 4'h1;
      else if (pick < 6)  op = 4'h2;
      else if (pick == 6) op = 4'hE;
      else if (pick == 7) op = 4'hF;
      else                op = 4'($urandom_range(3, 13));
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0), op);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
